// File: rtl/fifo_drain_scheduler.sv
// fifo_drain_scheduler
// Waits for the byte FIFO to accumulate data, then drains it in bursts of up to
// MAX_BURST bytes, handing each byte to the UART transmitter via start/busy.
module fifo_drain_scheduler #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned HOLD_CYC  = 1000,
   parameter int unsigned MAX_BURST = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              fifo_empty,
   input  logic              fifo_full,
   input  logic [DATA_W-1:0] fifo_rdata,
   output logic              fifo_pop,
   input  logic              tx_busy,
   output logic              tx_start,
   output logic [DATA_W-1:0] tx_data,
   output logic              busy,
   output logic [15:0]       byte_cnt
);

   localparam int unsigned HOLD_W  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

   localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOLD,
      S_POP,
      S_CAPT,
      S_START,
      S_WAIT_ACK,
      S_WAIT_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
   logic [BURST_W-1:0]  burst_inc;
   logic                tx_start_q, tx_start_d;
   logic [DATA_W-1:0]   tx_data_q, tx_data_d;
   logic [15:0]         byte_cnt_q, byte_cnt_d;

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         hold_cnt_q  <= '0;
         burst_cnt_q <= '0;
         tx_start_q  <= 1'b0;
         tx_data_q   <= '0;
         byte_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         burst_cnt_q <= burst_cnt_d;
         tx_start_q  <= tx_start_d;
         tx_data_q   <= tx_data_d;
         byte_cnt_q  <= byte_cnt_d;
      end
   end

   // Next-state, counter and handshake decode.
   // tx_start is registered: the "transmitter idle" decision is taken on the
   // tx_busy sampled in CAPT (or while stalled in START), so the one-cycle
   // pulse is visible during START without an input-to-output path.
   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      burst_cnt_d = burst_cnt_q;
      tx_start_d  = 1'b0;
      tx_data_d   = tx_data_q;
      byte_cnt_d  = byte_cnt_q;
      burst_inc   = burst_cnt_q + BURST_W'(1);

      unique case (state_q)
         S_IDLE: begin
            hold_cnt_d  = '0;
            burst_cnt_d = '0;
            if (en && !fifo_empty) begin
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            if (!en) begin
               state_d = S_IDLE;
            end else if (fifo_full) begin
               state_d = S_POP;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d = S_POP;
            end
         end
         S_POP: begin
            state_d = S_CAPT;
         end
         S_CAPT: begin
            tx_data_d  = fifo_rdata;
            tx_start_d = !tx_busy;
            state_d    = S_START;
         end
         S_START: begin
            if (tx_start_q) begin
               state_d = S_WAIT_ACK;
            end else begin
               tx_start_d = !tx_busy;
            end
         end
         S_WAIT_ACK: begin
            if (tx_busy) begin
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) begin
               byte_cnt_d  = byte_cnt_q + 16'd1;
               burst_cnt_d = burst_inc;
               if (burst_inc == BURST_MAX) begin
                  state_d = S_IDLE;
               end else if (!en || fifo_empty) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_POP;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign fifo_pop = (state_q == S_POP);
   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;
   assign busy     = (state_q != S_IDLE);
   assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_fifo_drain_scheduler.sv
// Self-checking bench for fifo_drain_scheduler: behavioural FIFO and UART
// transmitter models around the DUT, directed scenarios with random data and
// random transmitter timing, expectations derived from the drain rules.
module tb_fifo_drain_scheduler;

   localparam int unsigned DW   = 8;
   localparam int unsigned HOLD = 4;
   localparam int unsigned MAXB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          fifo_empty;
   logic          fifo_full;
   logic [DW-1:0] fifo_rdata;
   logic          fifo_pop;
   logic          tx_busy;
   logic          tx_start;
   logic [DW-1:0] tx_data;
   logic          busy;
   logic [15:0]   byte_cnt;

   int checks   = 0;
   int failures = 0;

   // free-running cycle index
   int cyc = 0;

   // FIFO model
   logic          push_en = 1'b0;
   logic [DW-1:0] push_val = '0;
   logic [DW-1:0] fq[$];
   int            fcount = 0;
   int            npop = 0;
   int            pop_empty_err = 0;

   // transmitter model
   logic tx_auto  = 1'b1;
   logic busy_man = 1'b0;
   logic busy_auto = 1'b0;
   int   ack_dly  = 0;
   int   busy_len = 10;
   int   pend = 0;
   int   left = 0;

   // monitor
   logic [DW-1:0] sent_q[$];
   int            gap_q[$];
   int            fall_cyc = 0;
   logic          prev_busy = 1'b0;
   logic          prev_start = 1'b0;
   int            dbl_err = 0;

   // expected transmit order
   logic [DW-1:0] exp_bytes[$];

   fifo_drain_scheduler #(
      .DATA_W   (DW),
      .HOLD_CYC (HOLD),
      .MAX_BURST(MAXB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .fifo_empty(fifo_empty),
      .fifo_full (fifo_full),
      .fifo_rdata(fifo_rdata),
      .fifo_pop  (fifo_pop),
      .tx_busy   (tx_busy),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .busy      (busy),
      .byte_cnt  (byte_cnt)
   );

   always #5 clk = ~clk;

   assign fifo_empty = (fcount == 0);
   assign tx_busy    = tx_auto ? busy_auto : busy_man;

   // cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   // FIFO: read data appears the cycle after a pop
   always @(posedge clk) begin
      if (fifo_pop === 1'b1) begin
         npop <= npop + 1;
         if (fq.size() == 0) pop_empty_err <= pop_empty_err + 1;
         else fifo_rdata <= fq.pop_front();
      end
      if (push_en) fq.push_back(push_val);
      fcount <= fq.size();
   end

   // transmitter: busy rises ack_dly cycles after the start edge, lasts busy_len cycles
   always @(posedge clk) begin
      if (!rst) begin
         busy_auto <= 1'b0;
         pend      <= 0;
         left      <= 0;
      end else if (tx_start === 1'b1) begin
         if (ack_dly == 0) begin
            busy_auto <= 1'b1;
            left      <= busy_len;
         end else begin
            pend <= ack_dly;
         end
      end else if (pend > 0) begin
         if (pend == 1) begin
            busy_auto <= 1'b1;
            left      <= busy_len;
         end
         pend <= pend - 1;
      end else if (busy_auto) begin
         if (left <= 1) busy_auto <= 1'b0;
         left <= left - 1;
      end
   end

   // monitor: sent bytes, busy-low to start gaps, start pulse width
   always @(posedge clk) begin
      if (tx_start === 1'b1) begin
         sent_q.push_back(tx_data);
         gap_q.push_back(cyc - fall_cyc);
         if (prev_start) dbl_err <= dbl_err + 1;
      end
      if (prev_busy === 1'b1 && tx_busy === 1'b0) fall_cyc <= cyc;
      prev_busy  <= tx_busy;
      prev_start <= tx_start;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand8();
      return DW'($urandom);
   endfunction

   task automatic push(input logic [DW-1:0] v);
      push_en  = 1'b1;
      push_val = v;
      exp_bytes.push_back(v);
      tick();
      push_en  = 1'b0;
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return fifo_pop;
         1:       return tx_start;
         2:       return tx_busy;
         3:       return busy;
         default: return ~busy;
      endcase
   endfunction

   task automatic wait_for(input int sel, input int budget, input string tag);
      int i;
      i = 0;
      while (sig(sel) !== 1'b1 && i < budget) begin
         tick();
         i++;
      end
      chk(tag, 32'(sig(sel)), 32'd1);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int i;
      i = 0;
      while (!(busy === 1'b0 && fifo_empty && tx_busy === 1'b0) && i < budget) begin
         tick();
         i++;
      end
      chk(tag, 32'(busy === 1'b0 && fifo_empty && tx_busy === 1'b0), 32'd1);
   endtask

   initial begin
      int exp_cnt;
      int t0;
      int tp;
      int n;
      int np0;
      int g0;
      int hits;
      int mism;

      rst = 1'b0;
      en = 1'b0;
      fifo_full = 1'b0;
      exp_cnt = 0;

      // reset state
      repeat (3) tick();
      chk("rst_fifo_pop", 32'(fifo_pop), 32'd0);
      chk("rst_tx_start", 32'(tx_start), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
      rst = 1'b1;
      tick();

      // single byte: pop HOLD+1 cycles after empty drops, start two cycles later
      en = 1'b1;
      ack_dly = 0;
      busy_len = 10;
      push(8'hA5);
      t0 = cyc;
      wait_for(0, 40, "t1_pop_seen");
      chk("t1_pop_latency", 32'(cyc - t0), 32'(HOLD + 1));
      tp = cyc;
      wait_for(1, 10, "t1_start_seen");
      chk("t1_start_latency", 32'(cyc - tp), 32'd2);
      chk("t1_tx_data", 32'(tx_data), 32'hA5);
      wait_idle("t1_idle", 60);
      exp_cnt = 1;
      chk("t1_byte_cnt", 32'(byte_cnt), 32'(exp_cnt));

      // fifo_full during the third HOLD cycle forces the pop early
      push(rand8());
      t0 = cyc;
      wait_for(3, 10, "t2_hold_seen");
      tick();
      tick();
      chk("t2_no_early_pop", 32'(fifo_pop), 32'd0);
      fifo_full = 1'b1;
      tick();
      fifo_full = 1'b0;
      chk("t2_full_pop", 32'(fifo_pop), 32'd1);
      chk("t2_full_latency", 32'(cyc - t0), 32'd4);
      wait_idle("t2_idle", 60);
      exp_cnt++;
      chk("t2_byte_cnt", 32'(byte_cnt), 32'(exp_cnt));

      // six bytes with MAX_BURST=4: burst of 4, IDLE+HOLD, burst of 2
      busy_len = int'($urandom_range(1, 6));
      ack_dly  = int'($urandom_range(0, 2));
      g0 = gap_q.size();
      for (int k = 1; k <= 6; k++) push(DW'(k));
      wait_idle("t3_idle", 400);
      exp_cnt += 6;
      chk("t3_byte_cnt", 32'(byte_cnt), 32'(exp_cnt));
      chk("t3_starts", 32'(gap_q.size() - g0), 32'd6);
      chk("t3_gap2", 32'(gap_q[g0+1]), 32'd3);
      chk("t3_gap3", 32'(gap_q[g0+2]), 32'd3);
      chk("t3_gap4", 32'(gap_q[g0+3]), 32'd3);
      chk("t3_gap_new_burst", 32'(gap_q[g0+4]), 32'(3 + 1 + HOLD));
      chk("t3_gap6", 32'(gap_q[g0+5]), 32'd3);

      // transmitter busy when START is reached
      tx_auto = 1'b0;
      busy_man = 1'b1;
      push(rand8());
      wait_for(0, 20, "t4_pop_seen");
      tick();
      tick();
      hits = 0;
      repeat (5) begin
         if (tx_start === 1'b1) hits++;
         tick();
      end
      chk("t4_start_held", 32'(hits), 32'd0);
      chk("t4_busy_in_start", 32'(busy), 32'd1);
      busy_man = 1'b0;
      tick();
      chk("t4_start_pulse", 32'(tx_start), 32'd1);
      tick();
      chk("t4_pulse_end", 32'(tx_start), 32'd0);
      hits = 0;
      repeat (3) begin
         tick();
         if (tx_start === 1'b1) hits++;
      end
      chk("t4_single_pulse", 32'(hits), 32'd0);
      busy_man = 1'b1;
      repeat (3) tick();
      busy_man = 1'b0;
      wait_idle("t4_idle", 40);
      exp_cnt++;
      chk("t4_byte_cnt", 32'(byte_cnt), 32'(exp_cnt));
      repeat (12) tick();
      tx_auto = 1'b1;

      // en dropped in WAIT_DONE with three bytes still queued
      busy_len = 10;
      ack_dly = 0;
      for (int k = 0; k < 4; k++) push(rand8());
      wait_for(1, 40, "t5_start_seen");
      wait_for(2, 10, "t5_txbusy_seen");
      tick();
      tick();
      en = 1'b0;
      wait_for(4, 30, "t5_back_idle");
      exp_cnt++;
      chk("t5_byte_cnt_one", 32'(byte_cnt), 32'(exp_cnt));
      np0 = npop;
      repeat (20) tick();
      chk("t5_no_pop", 32'(npop - np0), 32'd0);
      chk("t5_fifo_left", 32'(fcount), 32'd3);
      chk("t5_still_idle", 32'(busy), 32'd0);
      en = 1'b1;
      wait_idle("t5_idle", 200);
      exp_cnt += 3;
      chk("t5_byte_cnt_all", 32'(byte_cnt), 32'(exp_cnt));

      // random traffic with random transmitter timing
      busy_len = int'($urandom_range(1, 8));
      ack_dly  = int'($urandom_range(0, 3));
      n = int'($urandom_range(5, 10));
      for (int k = 0; k < n; k++) push(rand8());
      wait_idle("t6_idle", 600);
      exp_cnt += n;
      chk("t6_byte_cnt", 32'(byte_cnt), 32'(exp_cnt));

      // reset while waiting for the acknowledge
      ack_dly = 3;
      busy_len = 4;
      push(DW'($urandom_range(1, 255)));
      wait_for(1, 40, "t7_start_seen");
      tick();
      rst = 1'b0;
      tick();
      chk("t7_fifo_pop", 32'(fifo_pop), 32'd0);
      chk("t7_tx_start", 32'(tx_start), 32'd0);
      chk("t7_tx_data", 32'(tx_data), 32'd0);
      chk("t7_busy", 32'(busy), 32'd0);
      chk("t7_byte_cnt", 32'(byte_cnt), 32'd0);
      rst = 1'b1;
      exp_cnt = 0;
      tick();
      wait_idle("t7_idle", 40);
      chk("t7_byte_cnt_after", 32'(byte_cnt), 32'(exp_cnt));

      // byte counter wraps from 0xFFFF to 0x0000
      ack_dly = 0;
      busy_len = 2;
      force dut.byte_cnt_q = 16'hFFFF;
      tick();
      release dut.byte_cnt_q;
      tick();
      chk("t8_preload", 32'(byte_cnt), 32'hFFFF);
      exp_cnt = 16'hFFFF;
      push(rand8());
      wait_idle("t8_idle", 60);
      exp_cnt = (exp_cnt + 1) & 16'hFFFF;
      chk("t8_wrap", 32'(byte_cnt), 32'(exp_cnt));

      // global properties
      chk("sent_count", 32'(sent_q.size()), 32'(exp_bytes.size()));
      mism = 0;
      for (int k = 0; k < exp_bytes.size() && k < sent_q.size(); k++) begin
         if (sent_q[k] !== exp_bytes[k]) mism++;
      end
      chk("sent_order", 32'(mism), 32'd0);
      chk("pop_on_empty", 32'(pop_empty_err), 32'd0);
      chk("start_width", 32'(dbl_err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
